mult_div_unit: RTL and testbench

- Multi-cycle multiply/divide unit beside the ALU in the execute stage; owns the architectural HI/LO registers.
- Accepts one operation per start pulse on the same A/B/ctrl operand interface the ALU uses.
- Reports busy so the pipeline stalls MFHI/MFLO and further MDU ops, and presents HI/LO continuously for MFHI/MFLO.

---
 rtl/mult_div_unit_if.sv | 19 +
 rtl/mult_div_unit.sv | 181 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: operand/result bundle between the execute stage and the
// multiply/divide unit.
//   start, ctrl, A, B : launch request (same operand bus the ALU sees)
//   busy, done        : op in flight / one-cycle writeback pulse
//   hi, lo            : architectural HI/LO, always visible
// master = pipeline side, slave = MDU side.
interface mult_div_unit_if;
  logic        start;
  logic [3:0]  ctrl;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, ctrl, A, B, input  busy, done, hi, lo);
  modport slave  (input  start, ctrl, A, B, output busy, done, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit owning HI/LO.
//   clk, reset : rising-edge clock, async active-high reset
//   mdu        : mult_div_unit_if.slave (start/ctrl/A/B in; busy/done/hi/lo out)
// ctrl: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU.
// MDU_MADD_EN: when defined, ctrl 7/8 accumulate into {HI,LO}; otherwise
// they decode as no-ops and the accumulate adder is not built.
// The product is formed in the start cycle and held in a shadow register;
// HI/LO only change at the final writeback so no partial result leaks out.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 34
) (
  input logic           clk,
  input logic           reset,
  mult_div_unit_if.slave mdu
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state, state_n;
  logic [CW-1:0] cnt;
  logic        mul_fin, div_fin;
  logic [31:0] hi_q, lo_q;
  logic        done_q;
  logic [63:0] prod;
  logic [31:0] rem, qd, dsr, araw;
  logic        qneg, rneg, dz;
`ifdef MDU_MADD_EN
  logic        acc;
`endif

  // ---- decode / operand prep ----
  logic        is_mul, is_div, mul_sgn, div_sgn, a_neg, b_neg;
  logic [63:0] ax, bx;
  logic [31:0] amag, bmag;

  always_comb begin
    is_mul  = (mdu.ctrl == OP_MULT) || (mdu.ctrl == OP_MULTU);
    mul_sgn = (mdu.ctrl == OP_MULT);
`ifdef MDU_MADD_EN
    is_mul  = is_mul || (mdu.ctrl == OP_MADD) || (mdu.ctrl == OP_MADDU);
    mul_sgn = mul_sgn || (mdu.ctrl == OP_MADD);
`endif
    is_div  = (mdu.ctrl == OP_DIV) || (mdu.ctrl == OP_DIVU);
    div_sgn = (mdu.ctrl == OP_DIV);
    // 64-bit extension makes one multiplier serve both signednesses
    ax      = mul_sgn ? {{32{mdu.A[31]}}, mdu.A} : {32'd0, mdu.A};
    bx      = mul_sgn ? {{32{mdu.B[31]}}, mdu.B} : {32'd0, mdu.B};
    a_neg   = div_sgn & mdu.A[31];
    b_neg   = div_sgn & mdu.B[31];
    // -0x80000000 wraps to itself, which is the correct unsigned magnitude
    amag    = a_neg ? 32'd0 - mdu.A : mdu.A;
    bmag    = b_neg ? 32'd0 - mdu.B : mdu.B;
  end

  // ---- restoring divide step and sign fix ----
  // rem < dsr always holds, so the 33-bit difference never overflows and
  // its top bit is a clean "didn't fit" flag.
  logic [32:0] sh, diff;
  logic [31:0] quo_f, rem_f;

  always_comb begin
    sh    = {rem, qd[31]};
    diff  = sh - {1'b0, dsr};
    quo_f = qneg ? 32'd0 - qd  : qd;
    rem_f = rneg ? 32'd0 - rem : rem;
  end

  // ---- FSM ----
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_n;

  always_comb begin
    state_n = state;
    mul_fin = 1'b0;
    div_fin = 1'b0;
    unique case (state)
      IDLE: if (mdu.start && is_mul)      state_n = MUL;
            else if (mdu.start && is_div) state_n = DIV;
      MUL:  if (cnt == CW'(MULT_CYCLES)) begin
              state_n = IDLE;
              mul_fin = 1'b1;
            end
      DIV:  if (cnt == CW'(32)) state_n = FIX;
      // FIX also absorbs any idle padding beyond the 34 minimum cycles
      FIX:  if (cnt == CW'(DIV_CYCLES)) begin
              state_n = IDLE;
              div_fin = 1'b1;
            end
    endcase
  end

  // ---- datapath ----
  // cnt holds the number of edges since the start edge while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0; lo_q <= '0; done_q <= 1'b0; cnt <= '0;
      prod <= '0; rem <= '0; qd <= '0; dsr <= '0; araw <= '0;
      qneg <= 1'b0; rneg <= 1'b0; dz <= 1'b0;
`ifdef MDU_MADD_EN
      acc  <= 1'b0;
`endif
    end else begin
      done_q <= mul_fin | div_fin;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (mdu.start) begin
            if (is_mul) begin
              prod <= ax * bx;
              cnt  <= CW'(1);
`ifdef MDU_MADD_EN
              acc  <= (mdu.ctrl == OP_MADD) || (mdu.ctrl == OP_MADDU);
`endif
            end else if (is_div) begin
              qd   <= amag;
              dsr  <= bmag;
              rem  <= '0;
              araw <= mdu.A;
              dz   <= (mdu.B == 32'd0);
              qneg <= a_neg ^ b_neg;
              rneg <= a_neg;
              cnt  <= CW'(1);
            end else if (mdu.ctrl == OP_MTHI) begin
              hi_q <= mdu.A;
            end else if (mdu.ctrl == OP_MTLO) begin
              lo_q <= mdu.A;
            end
          end
        end
        MUL: begin
          cnt <= cnt + CW'(1);
          if (mul_fin) begin
`ifdef MDU_MADD_EN
            if (acc) {hi_q, lo_q} <= {hi_q, lo_q} + prod;
            else     {hi_q, lo_q} <= prod;
`else
            {hi_q, lo_q} <= prod;
`endif
          end
        end
        DIV: begin
          cnt <= cnt + CW'(1);
          qd  <= {qd[30:0], ~diff[32]};
          rem <= diff[32] ? sh[31:0] : diff[31:0];
        end
        FIX: begin
          cnt <= cnt + CW'(1);
          if (div_fin) begin
            if (dz) begin
              hi_q <= araw;
              lo_q <= '1;
            end else begin
              hi_q <= rem_f;
              lo_q <= quo_f;
            end
          end
        end
      endcase
    end
  end

  assign mdu.busy = (state != IDLE);
  assign mdu.done = done_q;
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors; expected writebacks go into a
// scoreboard queue and a negedge monitor pops/compares on every done pulse.
module tb_mult_div_unit;
  localparam int ML = 5;
  localparam int DL = 34;

  logic clk = 1'b0;
  logic reset = 1'b1;
  mult_div_unit_if bus();

  mult_div_unit #(.MULT_CYCLES(ML), .DIV_CYCLES(DL)) dut (
    .clk(clk), .reset(reset), .mdu(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       nm;
    logic [31:0] hi;
    logic [31:0] lo;
    int          at;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   ntests = 0;
  int   nfail  = 0;
  logic done_d = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // start is sampled at the second posedge; returns #1 after it
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.ctrl = op; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.ctrl = 4'd0;
  endtask

  task automatic expect_wb(input string nm, input logic [31:0] h, input logic [31:0] l, input int lat);
    exp_t e;
    e.nm = nm; e.hi = h; e.lo = l; e.at = cyc + lat;
    sbq.push_back(e);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_timeout"}, bus.busy, 0);
  endtask

  task automatic run(input string nm, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                     input int lat);
    issue(op, a, b);
    expect_wb(nm, h, l, lat);
    @(negedge clk);
    chk({nm, "_busy"}, bus.busy, 1);
    wait_idle(nm);
  endtask

  // Monitor: every done pulse must match the oldest expected writeback
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      chk("done_busy_excl", bus.busy, 0);
      chk("done_one_cycle", done_d, 0);
      chk("done_expected", {63'd0, sbq.size() != 0}, 1);
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        chk({mon_e.nm, "_cyc"}, cyc, mon_e.at);
        chk({mon_e.nm, "_hi"}, bus.hi, mon_e.hi);
        chk({mon_e.nm, "_lo"}, bus.lo, mon_e.lo);
      end
    end
    done_d <= bus.done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.ctrl = 4'd0; bus.A = 32'd0; bus.B = 32'd0;
    #12;
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    @(negedge clk); reset = 1'b0;

    // MTHI then MTLO on consecutive edges
    @(posedge clk); #1;
    bus.start = 1'b1; bus.ctrl = 4'd5; bus.A = 32'h12345678;
    @(posedge clk); #1;
    bus.ctrl = 4'd6; bus.A = 32'd1;
    @(negedge clk);
    chk("mthi_busy", bus.busy, 0);
    chk("mthi_hi", bus.hi, 32'h12345678);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.ctrl = 4'd0;
    @(negedge clk);
    chk("mtlo_busy", bus.busy, 0);
    chk("mtlo_hi", bus.hi, 32'h12345678);
    chk("mtlo_lo", bus.lo, 32'd1);
    chk("mt_done", bus.done, 0);

    // MTHI while MULT busy must be dropped
    issue(4'd1, 32'd3, 32'd4);
    expect_wb("mult_mthi_ign", 32'd0, 32'd12, ML);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.ctrl = 4'd5; bus.A = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.ctrl = 4'd0;
    @(negedge clk);
    chk("busy_ign_busy", bus.busy, 1);
    chk("busy_hold_hi", bus.hi, 32'h12345678);
    chk("busy_hold_lo", bus.lo, 32'd1);
    wait_idle("mult_mthi_ign");
    @(negedge clk);
    chk("mthi_ign_hi", bus.hi, 32'd0);

    run("mult",        4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, ML);
    run("multu",       4'd2, 32'hFFFFFFFE, 32'd3,        32'd2,        32'hFFFFFFFA, ML);
    run("mult_minmin", 4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        ML);
    run("multu_max",   4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        ML);
    run("div_nega",    4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DL);
    run("div_negb",    4'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DL);
    run("divu",        4'd4, 32'd7,        32'd2,        32'd1,        32'd3,        DL);
    run("divu_big",    4'd4, 32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, DL);
    run("div_zero",    4'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, DL);
    run("divu_zero",   4'd4, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, DL);
    run("div_ovf",     4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, DL);

    // ctrl 0 and an undefined code are no-ops
    issue(4'd0, 32'h11111111, 32'h2);
    @(negedge clk);
    chk("nop0_busy", bus.busy, 0);
    issue(4'hF, 32'h22222222, 32'h3);
    @(negedge clk);
    chk("nopf_busy", bus.busy, 0);
    chk("nop_hi", bus.hi, 32'd0);
    chk("nop_lo", bus.lo, 32'h80000000);

    // accumulate ops
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'hFFFFFFFF, 32'd0);
`ifdef MDU_MADD_EN
    run("maddu", 4'd8, 32'd1,        32'd1, 32'd1, 32'd0,        ML);
    run("madd",  4'd7, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, ML);
`else
    issue(4'd8, 32'd1, 32'd1);
    @(negedge clk);
    chk("maddu_off_busy", bus.busy, 0);
    issue(4'd7, 32'hFFFFFFFF, 32'd1);
    @(negedge clk);
    chk("madd_off_busy", bus.busy, 0);
    repeat (ML + 2) @(negedge clk);
    chk("madd_off_hi", bus.hi, 32'd0);
    chk("madd_off_lo", bus.lo, 32'hFFFFFFFF);
`endif

    // reset in the middle of a divide
    issue(4'd5, 32'h55, 32'd0);
    issue(4'd3, 32'd100, 32'd3);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_hi", bus.hi, 32'd0);
    chk("midrst_lo", bus.lo, 32'd0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    @(negedge clk); reset = 1'b0;
    repeat (DL + 10) @(negedge clk);
    chk("postrst_busy", bus.busy, 0);
    chk("postrst_lo", bus.lo, 32'd0);
    chk("sb_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
